dut_sub_seq: RTL and testbench
==============================

Name: dut_sub_seq

Overview:
- Multi-cycle unsigned subtractor: computes diff = a - b and a borrow flag, CHUNK bits per cycle, least-significant chunk first.
- It is the inverse-direction companion to the team's registered WIDTH-bit adder DUT and uses the same WIDTH default.
- It sits in the same RapidVPI bench template as a second DUT with valid/ready handshakes on both sides.
- It exercises multi-cycle scheduling and back-pressure in the C++ coroutine testbench.

Parameters:
- WIDTH, 40, operand and result width in bits (must be >= 1).
- CHUNK, 8, bits processed per compute cycle (1..WIDTH).
- NCHUNK, ceil(WIDTH/CHUNK) (localparam, 5 by default), number of compute cycles.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands a and b are presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend (unsigned).
- b  input  WIDTH  subtrahend (unsigned).
- out_valid  output  1  diff and borrow are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  (a - b) mod 2^WIDTH.
- borrow  output  1  1 iff a < b (unsigned).

Behaviour:
- Reset: rst is sampled low on a rising edge. In that cycle:
  - state becomes IDLE; chunk index and internal borrow become 0.
  - operand registers, diff and borrow become 0; out_valid becomes 0.
  - in_ready is forced to 0 while rst is low and equals (state==IDLE) otherwise.
- Reset mid-operation (CALC or DONE) abandons the transaction. No result is ever presented for it.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On an edge with in_valid&&in_ready: latch a and b, clear index and borrow, go to CALC.
- CALC:
  - in_ready=0 and out_valid=0.
  - Each edge processes chunk k = index (bits [k*CHUNK +: CHUNK], last chunk truncated at WIDTH-1).
  - diff chunk = a chunk - b chunk - borrow_in. borrow_out = 1 when the chunk result is negative.
  - The index increments each edge.
  - On the edge processing chunk NCHUNK-1: go to DONE and register the final borrow to the borrow port.
- Partial last chunk (WIDTH not a multiple of CHUNK): the borrow is taken at bit WIDTH-1. Bits above WIDTH-1 are ignored.
- DONE:
  - out_valid=1; diff and borrow are held stable.
  - On an edge with out_ready=1: go to IDLE and clear out_valid. diff and borrow keep their values.
  - out_ready=0 stalls indefinitely with no change.
- Latency: out_valid rises NCHUNK rising edges after the accept edge (5 by default).
- Throughput: one transaction per NCHUNK+2 cycles at best. Transactions never overlap.
- in_valid is ignored outside IDLE.
- out_ready is ignored outside DONE.
- a and b may change after the accept edge without affecting the result.
- diff is unspecified-but-stable during CALC (partially updated chunks are allowed). The bench checks diff only when out_valid=1.
- No X propagation: all registers have defined reset values.

Test Plan:
- Basic: a=100, b=58, in_valid pulse, out_ready=1 -> out_valid high exactly 5 edges after accept; diff=42, borrow=0; back in IDLE with in_ready=1 one edge later.
- Cross-chunk borrow: a=0x0000010000, b=0x0000000001 -> diff=0x000000FFFF, borrow=0.
- Underflow: a=0, b=1 -> diff=0xFFFFFFFFFF, borrow=1. Also a=b=0xFFFFFFFFFF -> diff=0, borrow=0.
- Back-pressure: result ready with out_ready=0 for 10 cycles -> out_valid stays 1 and diff/borrow stay stable; in_ready=0 throughout, and a new in_valid during the stall is ignored. Then raise out_ready -> single handshake, IDLE.
- Reset mid-operation: drive rst low for 1 edge 2 cycles after accept -> out_valid=0, diff=0, borrow=0, in_ready=1 after release. A following transaction a=7, b=9 gives diff=0xFFFFFFFFFE, borrow=1.
- Parameter sweep with WIDTH=13, CHUNK=4 (partial chunk), random a/b -> diff == (a-b) mod 2^13 and borrow == (a<b); latency 4 edges.

Source files
------------

// File: rtl/dut_sub_seq.sv
// -----------------------------------------------------------------------------
// dut_sub_seq
//   Multi-cycle unsigned subtractor. It computes diff = a - b (mod 2^WIDTH) and
//   a borrow flag. It processes CHUNK bits per cycle, least-significant chunk
//   first. Both sides use valid/ready handshakes. Only one transaction is in
//   flight at a time.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 1)
//   CHUNK  bits processed per compute cycle (1..WIDTH)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-low
//   in_valid   operands a/b presented
//   in_ready   block can accept operands (IDLE and not in reset)
//   a, b       minuend / subtrahend (unsigned)
//   out_valid  diff/borrow valid
//   out_ready  consumer accepts the result
//   diff       (a - b) mod 2^WIDTH
//   borrow     1 iff a < b (unsigned)
// -----------------------------------------------------------------------------
module dut_sub_seq #(
   parameter int WIDTH = 40,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int IXW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [IXW-1:0]   idx;
   logic             brw;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [CHUNK:0]   step;

   // Chunk subtract with borrow-in. The MSB of the result is the borrow-out:
   // it is set whenever the chunk difference went negative.
   function automatic logic [CHUNK:0] sub_chunk(input logic [CHUNK-1:0] x,
                                                input logic [CHUNK-1:0] y,
                                                input logic             bin);
      sub_chunk = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bin};
   endfunction

   // The operands shift right by CHUNK after every compute cycle, so the
   // current chunk is always the low CHUNK bits. On a partial last chunk the
   // bits above WIDTH-1 were shifted in as zeros. The borrow-out of that chunk
   // is therefore exactly the borrow at bit WIDTH-1.
   assign step = sub_chunk(a_sh[CHUNK-1:0], b_sh[CHUNK-1:0], brw);

   assign in_ready = rst && (state == IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         idx       <= '0;
         brw       <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         diff      <= '0;
         borrow    <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  idx   <= '0;
                  brw   <= 1'b0;
                  // Cleared so that chunks can be OR-ed into place below.
                  diff  <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               // Result bits that would land above WIDTH-1 fall off the
               // WIDTH-bit shift.
               diff <= diff | (WIDTH'(step[CHUNK-1:0]) << (idx * CHUNK));
               a_sh <= a_sh >> CHUNK;
               b_sh <= b_sh >> CHUNK;
               brw  <= step[CHUNK];
               idx  <= idx + 1'b1;
               if (idx == IXW'(NCHUNK - 1)) begin
                  borrow    <= step[CHUNK];
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dut_sub_seq.sv
// -----------------------------------------------------------------------------
// tb_dut_sub_seq
//   Directed self-checking bench for dut_sub_seq. It drives a default
//   instance (WIDTH=40, CHUNK=8) and a partial-chunk instance
//   (WIDTH=13, CHUNK=4) from a shared clock and reset.
// -----------------------------------------------------------------------------
module tb_dut_sub_seq;

   logic        clk = 1'b0;
   logic        rst;

   logic        in_valid, in_ready, out_valid, out_ready, borrow;
   logic [39:0] a, b, diff;

   logic        in_valid2, in_ready2, out_valid2, out_ready2, borrow2;
   logic [12:0] a2, b2, diff2;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dut_sub_seq u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow)
   );

   dut_sub_seq #(.WIDTH(13), .CHUNK(4)) u_dut2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid2),
      .in_ready  (in_ready2),
      .a         (a2),
      .b         (b2),
      .out_valid (out_valid2),
      .out_ready (out_ready2),
      .diff      (diff2),
      .borrow    (borrow2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction on the 40-bit instance with out_ready held high.
   task automatic run1(input string tag, input logic [39:0] av, input logic [39:0] bv,
                       input logic [39:0] ed, input logic eb);
      check({tag, " in_ready before"}, 64'(in_ready), 64'd1);
      a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      a = {8'h00, $urandom};
      b = {8'h00, $urandom};
      repeat (4) begin
         tick();
         check({tag, " out_valid early"}, 64'(out_valid), 64'd0);
      end
      tick();
      check({tag, " out_valid latency"}, 64'(out_valid), 64'd1);
      check({tag, " diff"}, 64'(diff), 64'(ed));
      check({tag, " borrow"}, 64'(borrow), 64'(eb));
      tick();
      check({tag, " out_valid after"}, 64'(out_valid), 64'd0);
      check({tag, " in_ready after"}, 64'(in_ready), 64'd1);
   endtask

   // One full transaction on the 13-bit instance (latency 4).
   task automatic run2(input string tag, input logic [12:0] av, input logic [12:0] bv,
                       input logic [12:0] ed, input logic eb);
      a2 = av; b2 = bv; in_valid2 = 1'b1; out_ready2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      a2 = 13'($urandom);
      b2 = 13'($urandom);
      repeat (3) begin
         tick();
         check({tag, " out_valid2 early"}, 64'(out_valid2), 64'd0);
      end
      tick();
      check({tag, " out_valid2 latency"}, 64'(out_valid2), 64'd1);
      check({tag, " diff2"}, 64'(diff2), 64'(ed));
      check({tag, " borrow2"}, 64'(borrow2), 64'(eb));
      tick();
      check({tag, " in_ready2 after"}, 64'(in_ready2), 64'd1);
   endtask

   initial begin
      logic [12:0] ra, rb, rd;
      logic        rbw;

      rst = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
      in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0;

      // Reset state.
      tick();
      tick();
      check("rst in_ready", 64'(in_ready), 64'd0);
      check("rst out_valid", 64'(out_valid), 64'd0);
      check("rst diff", 64'(diff), 64'd0);
      check("rst borrow", 64'(borrow), 64'd0);
      check("rst in_ready2", 64'(in_ready2), 64'd0);
      check("rst out_valid2", 64'(out_valid2), 64'd0);
      rst = 1'b1;
      #1;
      check("release in_ready", 64'(in_ready), 64'd1);
      check("release in_ready2", 64'(in_ready2), 64'd1);

      // Directed 40-bit vectors.
      run1("basic", 40'd100, 40'd58, 40'd42, 1'b0);
      run1("cross", 40'h00_0001_0000, 40'h00_0000_0001, 40'h00_0000_FFFF, 1'b0);
      run1("under", 40'd0, 40'd1, 40'hFF_FFFF_FFFF, 1'b1);
      run1("equal", 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 40'd0, 1'b0);

      // Back-pressure: 1000 - 1 = 999, stalled for 10 cycles.
      out_ready = 1'b0;
      a = 40'd1000; b = 40'd1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      check("bp out_valid", 64'(out_valid), 64'd1);
      check("bp diff", 64'(diff), 64'h3E7);
      check("bp borrow", 64'(borrow), 64'd0);
      in_valid = 1'b1; a = 40'd5; b = 40'd6;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp stall out_valid", 64'(out_valid), 64'd1);
         check("bp stall diff", 64'(diff), 64'h3E7);
         check("bp stall borrow", 64'(borrow), 64'd0);
         check("bp stall in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      check("bp handshake out_valid", 64'(out_valid), 64'd0);
      check("bp handshake in_ready", 64'(in_ready), 64'd1);
      tick();
      check("bp single out_valid", 64'(out_valid), 64'd0);
      check("bp idle diff", 64'(diff), 64'h3E7);

      // Reset mid-operation, two cycles after accept.
      a = 40'd5; b = 40'd3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("midrst out_valid", 64'(out_valid), 64'd0);
      check("midrst diff", 64'(diff), 64'd0);
      check("midrst borrow", 64'(borrow), 64'd0);
      check("midrst in_ready low", 64'(in_ready), 64'd0);
      rst = 1'b1;
      #1;
      check("midrst in_ready", 64'(in_ready), 64'd1);
      repeat (6) begin
         tick();
         check("midrst no result", 64'(out_valid), 64'd0);
      end
      run1("after rst", 40'd7, 40'd9, 40'hFF_FFFF_FFFE, 1'b1);

      // Partial-chunk instance: directed corners then random operands.
      for (int i = 0; i < 10; i++) begin
         if (i == 0) begin
            ra = 13'd0; rb = 13'd1;
         end else if (i == 1) begin
            ra = 13'h1FFF; rb = 13'd0;
         end else if (i == 2) begin
            ra = 13'h1000; rb = 13'h0001;
         end else begin
            ra = 13'($urandom_range(0, 8191));
            rb = 13'($urandom_range(0, 8191));
         end
         rd  = ra - rb;
         rbw = (ra < rb);
         run2("sweep", ra, rb, rd, rbw);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
